mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-access definitions for the fetch, load/store and memory-controller blocks.
//   MEM_BYTE / MEM_HALF / MEM_WORD : transfer size codes carried on req_size
//   size_bytes()                   : number of bytes moved for a size code
package mem_ctrl_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   // Code 2'b11 is not a distinct size; it moves a full word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         MEM_BYTE: return 3'd1;
         MEM_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns one byte/half/word request into a sequence of single-byte
// accesses to a synchronous-read RAM and reports completion with a one-cycle mem_rdy pulse.
// Ports:
//   clk_in, rst_in          clock, synchronous active-low reset
//   rdy_in                  global enable, 0 freezes the controller
//   req_valid/addr/size/wr/wdata  request (accepted only in idle)
//   mem_rdy, mem_data       completion pulse and zero-extended read data
//   ram_din                 byte read from RAM (one cycle after its address)
//   ram_dout, ram_a, ram_wr byte write data, byte address, write strobe
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_wr,
   input  logic [31:0] req_wdata,
   output logic        mem_rdy,
   output logic [31:0] mem_data,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e      state_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  n_q;     // bytes in the transfer
   logic [2:0]  cnt_q;   // read: byte index currently on ram_a; write: next byte to write
   logic [2:0]  cap_q;   // read: next byte to capture
   logic        pend_q;  // ram_din this cycle holds byte cap_q

   logic [2:0] cap_next;
   logic [2:0] cnt_inc;

   always_comb begin
      cap_next = cap_q + {2'b00, pend_q};
      cnt_inc  = cnt_q + 3'd1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q  <= StIdle;
         mem_rdy  <= 1'b0;
         mem_data <= '0;
         ram_a    <= '0;
         ram_dout <= '0;
         ram_wr   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         n_q      <= '0;
         cnt_q    <= '0;
         cap_q    <= '0;
         pend_q   <= 1'b0;
      end else if (!rdy_in) begin
         ram_wr <= 1'b0;
         // Park the address on the next uncaptured byte so its data is ready on resume.
         if (state_q == StRead) begin
            pend_q <= (cnt_q == cap_q) && (cnt_q < n_q);
            cnt_q  <= cap_q;
            ram_a  <= addr_q + {29'd0, cap_q};
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  n_q     <= size_bytes(req_size);
                  ram_a   <= req_addr;
                  cap_q   <= '0;
                  pend_q  <= 1'b0;
                  if (req_wr) begin
                     state_q  <= StWrite;
                     ram_wr   <= 1'b1;
                     ram_dout <= req_wdata[7:0];
                     cnt_q    <= 3'd1;
                  end else begin
                     state_q  <= StRead;
                     ram_wr   <= 1'b0;
                     mem_data <= '0;
                     cnt_q    <= '0;
                  end
               end
            end
            StRead: begin
               if (pend_q) begin
                  mem_data[{cap_q[1:0], 3'b000} +: 8] <= ram_din;
               end
               if (pend_q && (cap_next == n_q)) begin
                  state_q <= StDone;
                  mem_rdy <= 1'b1;
               end else begin
                  cap_q  <= cap_next;
                  // Data for the address now on ram_a arrives next cycle.
                  pend_q <= (cnt_q == cap_next) && (cnt_q < n_q);
                  if (cnt_q < n_q) begin
                     cnt_q <= cnt_inc;
                  end
                  if (cnt_inc < n_q) begin
                     ram_a <= addr_q + {29'd0, cnt_inc};
                  end
               end
            end
            StWrite: begin
               if (cnt_q == n_q) begin
                  state_q <= StDone;
                  mem_rdy <= 1'b1;
                  ram_wr  <= 1'b0;
               end else begin
                  ram_wr   <= 1'b1;
                  ram_a    <= addr_q + {29'd0, cnt_q};
                  ram_dout <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                  cnt_q    <= cnt_inc;
               end
            end
            StDone: begin
               state_q <= StIdle;
               mem_rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule
